// File: rtl/maxpool_relu_3ch_pkg.sv
// Shared defaults for the layer-1 pooling stage and the signed-max helper.
package maxpool_relu_3ch_pkg;
  localparam int MP_IN_W   = 12;
  localparam int MP_FMAP_W = 24;
  localparam int MP_FMAP_H = 24;

  // Callers sign-extend operands to 32 bits, so the same function serves any IN_W.
  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a >= b) ? a : b;
  endfunction
endpackage

// File: rtl/maxpool_relu_3ch_pool_lane.sv
// One channel of 2x2 max pooling: pair register, half-width row buffer, ReLU output register.
module maxpool_relu_3ch_pool_lane
  import maxpool_relu_3ch_pkg::*;
#(
  parameter int IN_W   = MP_IN_W,
  parameter int FMAP_W = MP_FMAP_W,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_odd_col,
  input  logic              i_odd_row,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [IN_W-1:0]   i_din,
  output logic [IN_W-1:0]   o_dout
);
  localparam int DEPTH = FMAP_W / 2;

  logic signed [IN_W-1:0] r_pair;
  logic signed [IN_W-1:0] r_row_buf [DEPTH];
  logic        [IN_W-1:0] r_dout;
  logic signed [IN_W-1:0] w_din, w_h, w_m;

  assign w_din  = $signed(i_din);
  assign w_h    = IN_W'(smax(32'(w_din), 32'(r_pair)));
  assign w_m    = IN_W'(smax(32'(r_row_buf[i_idx]), 32'(w_h)));
  assign o_dout = r_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pair <= '0;
      r_dout <= '0;
      for (int i = 0; i < DEPTH; i++) r_row_buf[i] <= '0;
    end else if (i_en) begin
      if (!i_odd_col) begin
        r_pair <= w_din;
      end else if (!i_odd_row) begin
        r_row_buf[i_idx] <= w_h;
      end else begin
        // ReLU on the sign bit of the 2x2 maximum
        r_dout <= w_m[IN_W-1] ? '0 : w_m;
      end
    end
  end
endmodule

// File: rtl/maxpool_relu_3ch.sv
// 2x2 stride-2 max pool + ReLU over three convolution channels in raster order.
module maxpool_relu_3ch
  import maxpool_relu_3ch_pkg::*;
#(
  parameter int IN_W   = MP_IN_W,
  parameter int FMAP_W = MP_FMAP_W,
  parameter int FMAP_H = MP_FMAP_H
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [IN_W-1:0] conv_in_1,
  input  logic [IN_W-1:0] conv_in_2,
  input  logic [IN_W-1:0] conv_in_3,
  output logic [IN_W-1:0] pool_out_1,
  output logic [IN_W-1:0] pool_out_2,
  output logic [IN_W-1:0] pool_out_3,
  output logic            valid_out,
  output logic            frame_done
);
  localparam int NCH   = 3;
  localparam int COL_W = $clog2(FMAP_W);
  localparam int ROW_W = $clog2(FMAP_H);
  localparam int IDX_W = COL_W - 1;

  if ((FMAP_W % 2) != 0 || (FMAP_H % 2) != 0) begin : g_dim_chk
    $error("maxpool_relu_3ch: FMAP_W and FMAP_H must be even");
  end

  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic                      r_valid_out, r_frame_done;
  logic                      w_last_col, w_last_row;
  logic [NCH-1:0][IN_W-1:0]  w_din, w_dout;

  assign w_last_col = (r_col == COL_W'(FMAP_W - 1));
  assign w_last_row = (r_row == ROW_W'(FMAP_H - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= valid_in & r_col[0] & r_row[0];
      r_frame_done <= valid_in & w_last_col & w_last_row;
      if (valid_in) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign w_din = {conv_in_3, conv_in_2, conv_in_1};

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    maxpool_relu_3ch_pool_lane #(
      .IN_W   (IN_W),
      .FMAP_W (FMAP_W),
      .IDX_W  (IDX_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_en      (valid_in),
      .i_odd_col (r_col[0]),
      .i_odd_row (r_row[0]),
      .i_idx     (r_col[COL_W-1:1]),
      .i_din     (w_din[g]),
      .o_dout    (w_dout[g])
    );
  end

  assign pool_out_1 = w_dout[0];
  assign pool_out_2 = w_dout[1];
  assign pool_out_3 = w_dout[2];
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_maxpool_relu_3ch.sv
// Scoreboard bench for maxpool_relu_3ch: frame-array reference model, queue of expected pooled pixels.
module tb_maxpool_relu_3ch;
  localparam int W    = 24;
  localparam int H    = 24;
  localparam int IW   = 12;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [IW-1:0] c1 = '0, c2 = '0, c3 = '0;
  logic [IW-1:0] p1, p2, p3;
  logic          valid_out, frame_done;

  maxpool_relu_3ch #(.IN_W(IW), .FMAP_W(W), .FMAP_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .conv_in_1  (c1),
    .conv_in_2  (c2),
    .conv_in_3  (c3),
    .pool_out_1 (p1),
    .pool_out_2 (p2),
    .pool_out_3 (p3),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e1;
    int e2;
    int e3;
    bit fd;
  } exp_t;

  exp_t q[$];
  int   pix [3][H][W];
  int   log_cur [3][NOUT];
  int   log_ref [3][NOUT];
  int   n_tot = 0, n_bad = 0;
  int   out_idx = 0;
  int   ns = 0;
  int   first_ns = 0;
  bit   got_first = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int max4relu(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 0) ? 0 : m;
  endfunction

  // Samples accepted since reset, counted on the capturing edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) ns <= 0;
    else if (valid_in) ns <= ns + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("spurious_vo", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ch1", int'($signed(p1)), e.e1);
          chk("ch2", int'($signed(p2)), e.e2);
          chk("ch3", int'($signed(p3)), e.e3);
          chk("fd", int'(frame_done), int'(e.fd));
          if (out_idx < NOUT) begin
            log_cur[0][out_idx] = int'($signed(p1));
            log_cur[1][out_idx] = int'($signed(p2));
            log_cur[2][out_idx] = int'($signed(p3));
          end
          out_idx++;
          if (!got_first) begin
            got_first = 1;
            first_ns  = ns;
          end
        end
      end else if (frame_done) begin
        chk("fd_stray", 1, 0);
      end
    end
  end

  task automatic drive_frame(input bit gaps, input int stop_at);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c >= stop_at) begin
          @(posedge clk); #1 valid_in = 1'b0;
          return;
        end
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1 valid_in = 1'b0;
            c1 = IW'($urandom); c2 = IW'($urandom); c3 = IW'($urandom);
          end
        end
        @(posedge clk); #1;
        valid_in = 1'b1;
        c1 = IW'(pix[0][r][c]);
        c2 = IW'(pix[1][r][c]);
        c3 = IW'(pix[2][r][c]);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          exp_t e;
          e.e1 = max4relu(pix[0][r-1][c-1], pix[0][r-1][c], pix[0][r][c-1], pix[0][r][c]);
          e.e2 = max4relu(pix[1][r-1][c-1], pix[1][r-1][c], pix[1][r][c-1], pix[1][r][c]);
          e.e3 = max4relu(pix[2][r-1][c-1], pix[2][r-1][c], pix[2][r][c-1], pix[2][r][c]);
          e.fd = (r == H - 1) && (c == W - 1);
          q.push_back(e);
        end
      end
    end
    @(posedge clk); #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    chk("q_empty", q.size(), 0);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) pix[k][r][c] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) pix[k][r][c] = int'($urandom_range(4095)) - 2048;
  endtask

  task automatic set_blk(input int k, input int bc, input int a, input int b, input int c, input int d);
    pix[k][0][2*bc]   = a;
    pix[k][0][2*bc+1] = b;
    pix[k][1][2*bc]   = c;
    pix[k][1][2*bc+1] = d;
  endtask

  task automatic new_frame();
    out_idx   = 0;
    got_first = 0;
  endtask

  initial begin
    int nmis;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p1", int'(p1), 0);
    chk("rst_p2", int'(p2), 0);
    chk("rst_p3", int'(p3), 0);
    chk("rst_vo", int'(valid_out), 0);
    chk("rst_fd", int'(frame_done), 0);
    @(negedge clk) rst = 1'b1;

    // Constant +100 frame, no gaps
    fill_const(100);
    new_frame();
    drive_frame(0, W * H);
    drain();
    chk("cnt_const", out_idx, NOUT);
    chk("lat_const", first_ns, W + 2);
    chk("const_last", log_cur[1][NOUT-1], 100);

    // Directed corner blocks on top of random data
    fill_rand();
    set_blk(0, 0, 5, -3, 42, 7);
    for (int k = 0; k < 3; k++) begin
      set_blk(k, 1, -1, -200, -2048, -5);
      set_blk(k, 2, -2048, 2047, 0, 0);
    end
    set_blk(0, 3, 10, 10, 10, 10);
    set_blk(1, 3, -10, -10, -10, -10);
    set_blk(2, 3, 2047, 2047, 2047, 2047);
    new_frame();
    drive_frame(0, W * H);
    drain();
    chk("cnt_dir", out_idx, NOUT);
    chk("blk0_ch1", log_cur[0][0], 42);
    for (int k = 0; k < 3; k++) begin
      chk("blk_neg", log_cur[k][1], 0);
      chk("blk_max", log_cur[k][2], 2047);
    end
    chk("blk3_ch1", log_cur[0][3], 10);
    chk("blk3_ch2", log_cur[1][3], 0);
    chk("blk3_ch3", log_cur[2][3], 2047);
    log_ref = log_cur;

    // Same frame with random gaps must give identical results
    new_frame();
    drive_frame(1, W * H);
    drain();
    chk("cnt_gap", out_idx, NOUT);
    nmis = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NOUT; i++)
        if (log_cur[k][i] != log_ref[k][i]) nmis++;
    chk("gap_eq", nmis, 0);

    // Reset in the middle of row 5, then a full random frame with gaps
    fill_rand();
    new_frame();
    drive_frame(1, 5 * W + 7);
    drain();
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("mrst_p1", int'(p1), 0);
    chk("mrst_p2", int'(p2), 0);
    chk("mrst_p3", int'(p3), 0);
    chk("mrst_vo", int'(valid_out), 0);
    repeat (2) @(posedge clk);
    q.delete();
    @(negedge clk) rst = 1'b1;
    fill_rand();
    new_frame();
    drive_frame(1, W * H);
    drain();
    chk("cnt_mrst", out_idx, NOUT);
    chk("lat_mrst", first_ns, W + 2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
